axi_decouple_shell_src: RTL and testbench

- AXI4 decoupler and outstanding-transaction tracker.
- Sits directly upstream of the shell-side AXI4 register slice. Its m_axi feeds the slice's s_axi.
- On request, it stops new AW/AR issue and drains all in-flight bursts. It then isolates the upstream (reconfigurable) side so the region can be reconfigured without leaving the downstream path with partial bursts or orphaned responses.
- Forwarding is combinational gating only: zero added latency, no data storage.

---
 rtl/axi_decouple_shell_src_if.sv | 77 +++++++
 rtl/axi_decouple_shell_src.sv | 165 ++++++++++++++++
 tb/tb_axi_decouple_shell_src.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_decouple_shell_src_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) shared by both sides of the shell decoupler.
// The master modport is the side issuing requests; the slave modport is the side accepting them.
interface axi_decouple_shell_src_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [3:0]          arregion;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_decouple_shell_src.sv
// AXI4 decoupler: tracks outstanding bursts, drains them on request and then isolates
// the upstream side. Payloads pass straight through; only valid/ready are gated.
module axi_decouple_shell_src #(
    parameter int unsigned MAX_OUTST = 16,
    parameter int unsigned CNT_BITS  = $clog2(MAX_OUTST + 1)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axi_decouple_shell_src_if.slave  s_axi,
    axi_decouple_shell_src_if.master m_axi,
    input  logic                     decouple_req,
    output logic                     decouple_ack,
    output logic [CNT_BITS-1:0]      wr_outst,
    output logic [CNT_BITS-1:0]      rd_outst
);

    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_OUTST);
    localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ISOL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] wr_outst_q, wr_outst_d;
    logic [CNT_BITS-1:0] rd_outst_q, rd_outst_d;
    logic [CNT_BITS-1:0] w_pend_q, w_pend_d;
    logic                decouple_ack_q, decouple_ack_d;

    logic run_en, flow_en, aw_en, ar_en, w_en;
    logic aw_hs, w_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last_hs;
    logic drained;

    // Gating includes aresetn so nothing leaks through while reset is held,
    // independent of the registered state.
    assign run_en  = aresetn & (state_q == RUN);
    assign flow_en = aresetn & (state_q != ISOL);
    assign aw_en   = run_en & (wr_outst_q < MAX_CNT) & (w_pend_q < MAX_CNT);
    assign ar_en   = run_en & (rd_outst_q < MAX_CNT);
    assign w_en    = flow_en & (w_pend_q != '0);

    assign m_axi.awid     = s_axi.awid;
    assign m_axi.awaddr   = s_axi.awaddr;
    assign m_axi.awlen    = s_axi.awlen;
    assign m_axi.awsize   = s_axi.awsize;
    assign m_axi.awburst  = s_axi.awburst;
    assign m_axi.awlock   = s_axi.awlock;
    assign m_axi.awcache  = s_axi.awcache;
    assign m_axi.awprot   = s_axi.awprot;
    assign m_axi.awqos    = s_axi.awqos;
    assign m_axi.awregion = s_axi.awregion;
    assign m_axi.awvalid  = s_axi.awvalid & aw_en;
    assign s_axi.awready  = m_axi.awready & aw_en;

    assign m_axi.wdata    = s_axi.wdata;
    assign m_axi.wstrb    = s_axi.wstrb;
    assign m_axi.wlast    = s_axi.wlast;
    assign m_axi.wvalid   = s_axi.wvalid & w_en;
    assign s_axi.wready   = m_axi.wready & w_en;

    assign s_axi.bid      = m_axi.bid;
    assign s_axi.bresp    = m_axi.bresp;
    assign s_axi.bvalid   = m_axi.bvalid & flow_en;
    assign m_axi.bready   = s_axi.bready & flow_en;

    assign m_axi.arid     = s_axi.arid;
    assign m_axi.araddr   = s_axi.araddr;
    assign m_axi.arlen    = s_axi.arlen;
    assign m_axi.arsize   = s_axi.arsize;
    assign m_axi.arburst  = s_axi.arburst;
    assign m_axi.arlock   = s_axi.arlock;
    assign m_axi.arcache  = s_axi.arcache;
    assign m_axi.arprot   = s_axi.arprot;
    assign m_axi.arqos    = s_axi.arqos;
    assign m_axi.arregion = s_axi.arregion;
    assign m_axi.arvalid  = s_axi.arvalid & ar_en;
    assign s_axi.arready  = m_axi.arready & ar_en;

    assign s_axi.rid      = m_axi.rid;
    assign s_axi.rdata    = m_axi.rdata;
    assign s_axi.rresp    = m_axi.rresp;
    assign s_axi.rlast    = m_axi.rlast;
    assign s_axi.rvalid   = m_axi.rvalid & flow_en;
    assign m_axi.rready   = s_axi.rready & flow_en;

    assign aw_hs     = s_axi.awvalid & m_axi.awready & aw_en;
    assign w_hs      = s_axi.wvalid & m_axi.wready & w_en;
    assign w_last_hs = w_hs & s_axi.wlast;
    assign b_hs      = m_axi.bvalid & s_axi.bready & flow_en;
    assign ar_hs     = s_axi.arvalid & m_axi.arready & ar_en;
    assign r_hs      = m_axi.rvalid & s_axi.rready & flow_en;
    assign r_last_hs = r_hs & m_axi.rlast;

    assign drained = (wr_outst_q == '0) && (rd_outst_q == '0) && (w_pend_q == '0) &&
                     !(aw_hs || w_hs || b_hs || ar_hs || r_hs);

    always_comb begin
        wr_outst_d = wr_outst_q;
        if (aw_hs && !b_hs) begin
            wr_outst_d = wr_outst_q + ONE;
        end else if (b_hs && !aw_hs && (wr_outst_q != '0)) begin
            wr_outst_d = wr_outst_q - ONE;
        end

        rd_outst_d = rd_outst_q;
        if (ar_hs && !r_last_hs) begin
            rd_outst_d = rd_outst_q + ONE;
        end else if (r_last_hs && !ar_hs && (rd_outst_q != '0)) begin
            rd_outst_d = rd_outst_q - ONE;
        end

        w_pend_d = w_pend_q;
        if (aw_hs && !w_last_hs) begin
            w_pend_d = w_pend_q + ONE;
        end else if (w_last_hs && !aw_hs) begin
            w_pend_d = w_pend_q - ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (decouple_req) state_d = DRAIN;
            DRAIN: begin
                if (!decouple_req) begin
                    state_d = RUN;
                end else if (drained) begin
                    state_d = ISOL;
                end
            end
            ISOL:    if (!decouple_req) state_d = RUN;
            default: state_d = RUN;
        endcase
        decouple_ack_d = (state_d == ISOL);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= RUN;
            wr_outst_q     <= '0;
            rd_outst_q     <= '0;
            w_pend_q       <= '0;
            decouple_ack_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_outst_q     <= wr_outst_d;
            rd_outst_q     <= rd_outst_d;
            w_pend_q       <= w_pend_d;
            decouple_ack_q <= decouple_ack_d;
        end
    end

    assign decouple_ack = decouple_ack_q;
    assign wr_outst     = wr_outst_q;
    assign rd_outst     = rd_outst_q;

    // A B or final R with nothing outstanding means the downstream broke protocol.
    a_wr_underflow : assert property (@(posedge aclk) disable iff (!aresetn)
        !(b_hs && !aw_hs && (wr_outst_q == '0)));
    a_rd_underflow : assert property (@(posedge aclk) disable iff (!aresetn)
        !(r_last_hs && !ar_hs && (rd_outst_q == '0)));

endmodule

// File: tb/tb_axi_decouple_shell_src.sv
// Directed, table-driven bench for axi_decouple_shell_src with hand-written sequences
// for saturation, drain/isolate, aborted drain and asynchronous reset.
module tb_axi_decouple_shell_src;

    logic       aclk;
    logic       aresetn;
    logic       req;
    logic       ack;
    logic [4:0] wo;
    logic [4:0] ro;

    int unsigned checks;
    int unsigned failures;

    axi_decouple_shell_src_if s_if ();
    axi_decouple_shell_src_if m_if ();

    axi_decouple_shell_src #(.MAX_OUTST(16)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axi        (s_if),
        .m_axi        (m_if),
        .decouple_req (req),
        .decouple_ack (ack),
        .wr_outst     (wo),
        .rd_outst     (ro)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Input vector: {awvalid,awready}_{wvalid,wlast,wready}_{bvalid,bready}_{arvalid,arready}_{rvalid,rlast,rready}_{req}
    localparam logic [12:0] I_IDLE = 13'b00_000_00_00_000_0;
    localparam logic [12:0] I_AW   = 13'b11_000_00_00_000_0;
    localparam logic [12:0] I_WL   = 13'b00_111_00_00_000_0;
    localparam logic [12:0] I_B    = 13'b00_000_11_00_000_0;
    localparam logic [12:0] I_AR   = 13'b00_000_00_11_000_0;
    localparam logic [12:0] I_RL   = 13'b00_000_00_00_111_0;
    localparam logic [12:0] I_REQ  = 13'b00_000_00_00_000_1;
    localparam logic [12:0] I_ALL  = 13'b11_101_11_11_101_0;

    // Gate vector: {m.awvalid,s.awready}_{m.wvalid,s.wready}_{m.arvalid,s.arready}_{s.bvalid,s.rvalid}
    typedef struct {
        logic [12:0] in;
        logic [7:0]  g;
        logic [4:0]  wo;
        logic [4:0]  ro;
        logic        ack;
    } vec_t;

    vec_t tbl[28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [12:0] v);
        {s_if.awvalid, m_if.awready, s_if.wvalid, s_if.wlast, m_if.wready,
         m_if.bvalid, s_if.bready, s_if.arvalid, m_if.arready,
         m_if.rvalid, m_if.rlast, s_if.rready, req} = v;
    endtask

    function automatic logic [7:0] gates();
        return {m_if.awvalid, s_if.awready, m_if.wvalid, s_if.wready,
                m_if.arvalid, s_if.arready, s_if.bvalid, s_if.rvalid};
    endfunction

    task automatic cyc(input logic [12:0] v, input logic [7:0] eg, input logic [4:0] ewo,
                       input logic [4:0] ero, input logic eack, input string tag);
        @(negedge aclk);
        set_in(v);
        #1;
        chk($sformatf("%s.gate", tag), 32'(gates()), 32'(eg));
        @(posedge aclk);
        #1;
        chk($sformatf("%s.wr_outst", tag), 32'(wo), 32'(ewo));
        chk($sformatf("%s.rd_outst", tag), 32'(ro), 32'(ero));
        chk($sformatf("%s.ack", tag), 32'(ack), 32'(eack));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // W before AW, write burst, B, reads, simultaneous inc/dec, zero-count decouple.
        tbl[0]  = '{I_IDLE,                  8'b00_00_00_00, 5'd0, 5'd0, 1'b0};
        tbl[1]  = '{13'b00_101_00_00_000_0,  8'b00_00_00_00, 5'd0, 5'd0, 1'b0};
        tbl[2]  = '{13'b00_101_00_00_000_0,  8'b00_00_00_00, 5'd0, 5'd0, 1'b0};
        tbl[3]  = '{13'b00_101_00_00_000_0,  8'b00_00_00_00, 5'd0, 5'd0, 1'b0};
        tbl[4]  = '{13'b11_101_00_00_000_0,  8'b11_00_00_00, 5'd1, 5'd0, 1'b0};
        tbl[5]  = '{13'b00_101_00_00_000_0,  8'b00_11_00_00, 5'd1, 5'd0, 1'b0};
        tbl[6]  = '{13'b00_101_00_00_000_0,  8'b00_11_00_00, 5'd1, 5'd0, 1'b0};
        tbl[7]  = '{13'b00_101_00_00_000_0,  8'b00_11_00_00, 5'd1, 5'd0, 1'b0};
        tbl[8]  = '{I_WL,                    8'b00_11_00_00, 5'd1, 5'd0, 1'b0};
        tbl[9]  = '{13'b00_101_00_00_000_0,  8'b00_00_00_00, 5'd1, 5'd0, 1'b0};
        tbl[10] = '{I_B,                     8'b00_00_00_10, 5'd0, 5'd0, 1'b0};
        tbl[11] = '{I_AR,                    8'b00_00_11_00, 5'd0, 5'd1, 1'b0};
        tbl[12] = '{13'b00_000_00_00_101_0,  8'b00_00_00_01, 5'd0, 5'd1, 1'b0};
        tbl[13] = '{I_RL,                    8'b00_00_00_01, 5'd0, 5'd0, 1'b0};
        tbl[14] = '{I_AW,                    8'b11_00_00_00, 5'd1, 5'd0, 1'b0};
        tbl[15] = '{13'b11_000_11_11_000_0,  8'b11_00_11_10, 5'd1, 5'd1, 1'b0};
        tbl[16] = '{13'b00_000_00_11_111_0,  8'b00_00_11_01, 5'd1, 5'd1, 1'b0};
        tbl[17] = '{I_WL,                    8'b00_11_00_00, 5'd1, 5'd1, 1'b0};
        tbl[18] = '{I_WL,                    8'b00_11_00_00, 5'd1, 5'd1, 1'b0};
        tbl[19] = '{I_B,                     8'b00_00_00_10, 5'd0, 5'd1, 1'b0};
        tbl[20] = '{I_RL,                    8'b00_00_00_01, 5'd0, 5'd0, 1'b0};
        tbl[21] = '{I_REQ,                   8'b00_00_00_00, 5'd0, 5'd0, 1'b0};
        tbl[22] = '{13'b11_000_00_11_000_1,  8'b00_00_00_00, 5'd0, 5'd0, 1'b1};
        tbl[23] = '{13'b11_101_11_11_101_1,  8'b00_00_00_00, 5'd0, 5'd0, 1'b1};
        tbl[24] = '{13'b11_000_00_11_000_0,  8'b00_00_00_00, 5'd0, 5'd0, 1'b0};
        tbl[25] = '{13'b11_000_00_11_000_0,  8'b11_00_11_00, 5'd1, 5'd1, 1'b0};
        tbl[26] = '{13'b00_111_00_00_111_0,  8'b00_11_00_01, 5'd1, 5'd0, 1'b0};
        tbl[27] = '{I_B,                     8'b00_00_00_10, 5'd0, 5'd0, 1'b0};

        s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0;
        s_if.awburst = '0; s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0;
        s_if.awqos = '0; s_if.awregion = '0;
        s_if.wdata = '0; s_if.wstrb = '0;
        s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
        s_if.arburst = '0; s_if.arlock = 1'b0; s_if.arcache = '0; s_if.arprot = '0;
        s_if.arqos = '0; s_if.arregion = '0;
        m_if.bid = '0; m_if.bresp = '0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0;

        // Reset with traffic offered: nothing may pass.
        aresetn = 1'b0;
        set_in(I_ALL);
        #12;
        chk("rst.gate", 32'(gates()), 32'h0);
        chk("rst.bready", 32'(m_if.bready), 32'h0);
        chk("rst.wr_outst", 32'(wo), 32'h0);
        chk("rst.rd_outst", 32'(ro), 32'h0);
        chk("rst.ack", 32'(ack), 32'h0);
        set_in(I_IDLE);
        @(negedge aclk);
        aresetn = 1'b1;

        // Payload pass-through, zero latency.
        s_if.awaddr = 32'hDEAD_BEEF; s_if.awlen = 8'd3; s_if.wdata = 32'hCAFE_F00D;
        m_if.rdata = 32'h1234_5678; m_if.bresp = 2'b10;
        #1;
        chk("pt.awaddr", m_if.awaddr, 32'hDEAD_BEEF);
        chk("pt.awlen", 32'(m_if.awlen), 32'd3);
        chk("pt.wdata", m_if.wdata, 32'hCAFE_F00D);
        chk("pt.rdata", s_if.rdata, 32'h1234_5678);
        chk("pt.bresp", 32'(s_if.bresp), 32'h2);

        for (int i = 0; i < 28; i++) begin
            cyc(tbl[i].in, tbl[i].g, tbl[i].wo, tbl[i].ro, tbl[i].ack, $sformatf("vec%0d", i));
        end

        // AR saturation at 16 outstanding.
        for (int i = 0; i < 16; i++) cyc(I_AR, 8'b00_00_11_00, 5'd0, 5'(i + 1), 1'b0, "sat.ar");
        cyc(I_AR,        8'b00_00_00_00, 5'd0, 5'd16, 1'b0, "sat.ar17_blk");
        cyc(I_AR | I_RL, 8'b00_00_00_01, 5'd0, 5'd15, 1'b0, "sat.rlast");
        cyc(I_AR,        8'b00_00_11_00, 5'd0, 5'd16, 1'b0, "sat.ar17_ok");
        for (int i = 0; i < 16; i++) cyc(I_RL, 8'b00_00_00_01, 5'd0, 5'(15 - i), 1'b0, "sat.drain");

        // Drain with 2 writes + 1 read in flight; AW in the request cycle still counts.
        cyc(I_AW,                 8'b11_00_00_00, 5'd1, 5'd0, 1'b0, "dr.aw1");
        cyc(I_AW,                 8'b11_00_00_00, 5'd2, 5'd0, 1'b0, "dr.aw2");
        cyc(I_AR,                 8'b00_00_11_00, 5'd2, 5'd1, 1'b0, "dr.ar");
        cyc(I_AW | I_REQ,         8'b11_00_00_00, 5'd3, 5'd1, 1'b0, "dr.req_aw");
        cyc(I_AW | I_AR | I_REQ,  8'b00_00_00_00, 5'd3, 5'd1, 1'b0, "dr.blocked");
        for (int i = 0; i < 3; i++) cyc(I_WL | I_REQ, 8'b00_11_00_00, 5'd3, 5'd1, 1'b0, "dr.wl");
        cyc(I_RL | I_REQ,         8'b00_00_00_01, 5'd3, 5'd0, 1'b0, "dr.rl");
        cyc(I_B | I_REQ,          8'b00_00_00_10, 5'd2, 5'd0, 1'b0, "dr.b1");
        cyc(I_B | I_REQ,          8'b00_00_00_10, 5'd1, 5'd0, 1'b0, "dr.b2");
        cyc(I_B | I_REQ,          8'b00_00_00_10, 5'd0, 5'd0, 1'b0, "dr.b3");
        cyc(I_REQ,                8'b00_00_00_00, 5'd0, 5'd0, 1'b1, "dr.ack");
        @(negedge aclk);
        set_in(I_ALL | I_REQ);
        #1;
        chk("isol.bready", 32'(m_if.bready), 32'h0);
        chk("isol.rready", 32'(m_if.rready), 32'h0);
        cyc(I_ALL | I_REQ,        8'b00_00_00_00, 5'd0, 5'd0, 1'b1, "isol.hold");
        cyc(I_IDLE,               8'b00_00_00_00, 5'd0, 5'd0, 1'b0, "isol.release");
        cyc(I_AW,                 8'b11_00_00_00, 5'd1, 5'd0, 1'b0, "isol.run_aw");
        cyc(I_WL,                 8'b00_11_00_00, 5'd1, 5'd0, 1'b0, "isol.run_wl");
        cyc(I_B,                  8'b00_00_00_10, 5'd0, 5'd0, 1'b0, "isol.run_b");

        // Aborted drain: request dropped before completion, AW resumes next cycle.
        cyc(I_AW,          8'b11_00_00_00, 5'd1, 5'd0, 1'b0, "ab.aw");
        cyc(I_REQ,         8'b00_00_00_00, 5'd1, 5'd0, 1'b0, "ab.req1");
        cyc(I_AW | I_REQ,  8'b00_00_00_00, 5'd1, 5'd0, 1'b0, "ab.req2");
        cyc(I_AW | I_REQ,  8'b00_00_00_00, 5'd1, 5'd0, 1'b0, "ab.req3");
        cyc(I_AW,          8'b00_00_00_00, 5'd1, 5'd0, 1'b0, "ab.drop");
        cyc(I_AW,          8'b11_00_00_00, 5'd2, 5'd0, 1'b0, "ab.resume");
        cyc(I_WL,          8'b00_11_00_00, 5'd2, 5'd0, 1'b0, "ab.wl1");
        cyc(I_WL,          8'b00_11_00_00, 5'd2, 5'd0, 1'b0, "ab.wl2");
        cyc(I_B,           8'b00_00_00_10, 5'd1, 5'd0, 1'b0, "ab.b1");
        cyc(I_B,           8'b00_00_00_10, 5'd0, 5'd0, 1'b0, "ab.b2");

        // Asynchronous reset mid-cycle with 5 writes outstanding.
        for (int i = 0; i < 5; i++) cyc(I_AW, 8'b11_00_00_00, 5'(i + 1), 5'd0, 1'b0, "ar.aw");
        @(negedge aclk);
        set_in(I_AW);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst.wr_outst", 32'(wo), 32'h0);
        chk("arst.ack", 32'(ack), 32'h0);
        chk("arst.awvalid", 32'(m_if.awvalid), 32'h0);
        chk("arst.awready", 32'(s_if.awready), 32'h0);
        @(posedge aclk);
        #1;
        chk("arst.hold_wr_outst", 32'(wo), 32'h0);
        @(negedge aclk);
        set_in(I_IDLE);
        aresetn = 1'b1;
        cyc(I_AW,  8'b11_00_00_00, 5'd1, 5'd0, 1'b0, "arst.run_aw");
        cyc(I_WL,  8'b00_11_00_00, 5'd1, 5'd0, 1'b0, "arst.wl");
        cyc(I_WL,  8'b00_00_00_00, 5'd1, 5'd0, 1'b0, "arst.wpend_clr");
        cyc(I_B,   8'b00_00_00_10, 5'd0, 5'd0, 1'b0, "arst.b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
